alu_issue_ctrl: RTL

Instruction issue/control unit that sits in front of the project's combinational ALU. It accepts 16-bit CR16-style instruction words over a valid/ready handshake and decodes them into ALU opcode/opext and operands. It reads a 16x16 register file, drives the ALU, and captures its result and CLFZN flags. It writes the result back and updates the PSR flag register.

---
 rtl/alu_issue_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/control front end for the combinational ALU.
// Decodes CR16-style words, reads operands, retires results and flags.
module alu_issue_ctrl #(
   parameter int NREGS = 16,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [3:0]    alu_opcode,
   output logic [3:0]    alu_opext,
   input  logic [DW-1:0] alu_s,
   input  logic [4:0]    alu_flags,
   output logic [4:0]    psr,
   output logic          done,
   output logic          illegal,
   input  logic [3:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC,
      WB
   } state_t;

   state_t state_q, state_d;

   logic [15:0]   ir;
   logic          ready_q;
   logic [DW-1:0] rf [NREGS];
   logic [DW-1:0] res_q;
   logic [4:0]    flg_q;

   logic [3:0] op, ext, rd, rs;
   logic       legal, nop, is_imm, sext;
   logic       mov, src_a, cmp;
   logic       wb_en, psr_en;
   logic [DW-1:0] imm, rd_val, rs_val;
   logic [DW-1:0] opa, opb;

   assign op  = ir[15:12];
   assign rd  = ir[11:8];
   assign ext = ir[7:4];
   assign rs  = ir[3:0];

   assign instr_ready = ready_q;
   assign dbg_data    = rf[dbg_addr];

   // Classify the latched word: legality, operand routing, compare forms.
   always_comb begin
      legal  = 1'b0;
      nop    = 1'b0;
      is_imm = 1'b0;
      sext   = 1'b0;
      mov    = 1'b0;
      src_a  = 1'b0;
      cmp    = 1'b0;
      unique case (1'b1)
         (op == 4'h0) && (ext == 4'h0): begin
            legal = 1'b1;
            nop   = 1'b1;
         end
         (op == 4'h0) && (ext != 4'h0): begin
            legal = ext inside {4'h1, 4'h2, 4'h3,
                                4'h5, 4'h6, 4'h7,
                                4'h9, 4'hB, 4'hD,
                                4'hE};
            mov   = (ext == 4'hD);
            src_a = (ext == 4'hE);
            cmp   = (ext == 4'hB);
         end
         op == 4'hA: begin
            legal = (ext >= 4'h1) && (ext <= 4'h6);
            src_a = ext inside {4'h1, 4'h3, 4'h4};
            cmp   = (ext == 4'h2);
         end
         op inside {4'h5, 4'h7, 4'h9, 4'hB}: begin
            legal  = 1'b1;
            is_imm = 1'b1;
            sext   = 1'b1;
            cmp    = (op == 4'hB);
         end
         op inside {4'h6, 4'h8, 4'hE}: begin
            legal  = 1'b1;
            is_imm = 1'b1;
         end
         op == 4'hD: begin
            legal  = 1'b1;
            is_imm = 1'b1;
            mov    = 1'b1;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

   assign wb_en  = legal && !nop && !cmp;
   assign psr_en = legal && !nop;

   assign imm = sext ? {{(DW-8){ir[7]}}, ir[7:0]}
                     : {{(DW-8){1'b0}}, ir[7:0]};

   assign rd_val = rf[rd];
   assign rs_val = rf[rs];

   // Operand muxes: moves pass through A, NOT/shift-reg take Rsrc on A.
   always_comb begin
      opa = rd_val;
      opb = is_imm ? imm : rs_val;
      if (mov) begin
         opa = is_imm ? imm : rs_val;
         opb = '0;
      end else if (src_a) begin
         opa = rs_val;
      end
   end

   // Next-state sequencing through the fixed four-cycle issue.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (instr_valid && instr_ready) state_d = READ;
         READ: state_d = EXEC;
         EXEC: state_d = WB;
         WB:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, ready flag and instruction latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         ir      <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         if (state_q == IDLE && instr_valid && ready_q)
            ir <= instr;
      end
   end

   // Operand and opcode registers that drive the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         alu_opext  <= '0;
      end else if (state_q == READ) begin
         alu_a      <= opa;
         alu_b      <= opb;
         alu_opcode <= op;
         alu_opext  <= ext;
      end
   end

   // Capture the settled ALU result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         flg_q <= '0;
      end else if (state_q == EXEC) begin
         res_q <= alu_s;
         flg_q <= alu_flags;
      end
   end

   // Retire: register write-back, flag update and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= '0;
         psr     <= '0;
         done    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         done    <= (state_q == WB);
         illegal <= (state_q == WB) && !legal;
         if (state_q == WB) begin
            if (wb_en)
               rf[rd] <= res_q;
            if (psr_en)
               psr <= flg_q;
         end
      end
   end

endmodule
